// File: rtl/cpu16_alu_mul_seq_pkg.sv
// ----------------------------------------------------------------------------
// cpu16_alu_mul_seq_pkg
// Shared definitions for the sequential 16x16 shift-and-add multiplier.
//   state_t    : FSM state encoding (IDLE / RUN / DONE)
//   MUL_ITER   : number of iterations of a full (non early-exit) multiply
//   CNT_W      : width of the iteration counter
//   add_carry  : carry out of bit 15 rebuilt from adder operands and result,
//                since the shared adder exposes no carry port
// ----------------------------------------------------------------------------
package cpu16_alu_mul_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int MUL_ITER = 16;
  localparam int CNT_W    = 5;

  // Carry out of a 16-bit add, from the top bits of both operands and sum.
  function automatic logic add_carry(input logic a15, input logic b15,
                                     input logic s15);
    return (a15 & b15) | ((a15 | b15) & ~s15);
  endfunction

endpackage

// File: rtl/cpu16_alu_add.sv
// ----------------------------------------------------------------------------
// cpu16_alu_add
// Combinational 16-bit adder of the cpu16 ALU, modulo 2^16, no carry ports.
//   A, B : operands
//   Y    : (A + B) mod 2^16
// ----------------------------------------------------------------------------
module cpu16_alu_add (
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] Y
);

  assign Y = A + B;

endmodule

// File: rtl/cpu16_alu_mul_seq.sv
// ----------------------------------------------------------------------------
// cpu16_alu_mul_seq
// Sequential 16x16 unsigned shift-and-add multiplier. One iteration per clock,
// using the shared cpu16_alu_add as its only adder. Returns product bits
// [15:0] and a flag that is set when the full product is 2^16 or more.
//   CLK   : clock, rising edge
//   RST   : asynchronous active-high reset
//   START : request a multiply (accepted in IDLE or DONE)
//   A, B  : multiplicand / multiplier, captured on an accepted START
//   BUSY  : high while iterating
//   DONE  : one-cycle pulse when OUT/OVF are updated
//   OUT   : product bits [15:0]
//   OVF   : product >= 2^16
// Parameter EARLY_EXIT: 1 = stop once the remaining multiplier bits are zero.
// ----------------------------------------------------------------------------
module cpu16_alu_mul_seq
  import cpu16_alu_mul_seq_pkg::*;
#(
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        BUSY,
  output logic        DONE,
  output logic [15:0] OUT,
  output logic        OVF
);

  state_t           state;
  logic [15:0]      mcand;
  logic [15:0]      mplier;
  logic [15:0]      acc;
  logic [CNT_W-1:0] cnt;
  logic             lost;
  logic             ovf_acc;

  logic [15:0]      sum;
  logic [15:0]      acc_next;
  logic             ovf_next;
  logic             last_iter;

  cpu16_alu_add u_add (
    .A (acc),
    .B (mcand),
    .Y (sum)
  );

  // Result of the current iteration. Overflow is sticky: an add that carries
  // out, or an add of a multiplicand that has already lost a bit off the top,
  // both mean the true product needs more than 16 bits.
  always_comb begin
    acc_next  = acc;
    ovf_next  = ovf_acc;
    if (mplier[0]) begin
      acc_next = sum;
      if (add_carry(acc[15], mcand[15], sum[15]) || lost) begin
        ovf_next = 1'b1;
      end
    end
    // Early exit looks at the multiplier as it will be after this shift.
    last_iter = (cnt == CNT_W'(MUL_ITER - 1)) ||
                (EARLY_EXIT && (mplier[15:1] == 15'd0));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= ST_IDLE;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      OUT     <= 16'd0;
      OVF     <= 1'b0;
      mcand   <= 16'd0;
      mplier  <= 16'd0;
      acc     <= 16'd0;
      cnt     <= '0;
      lost    <= 1'b0;
      ovf_acc <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (START) begin
            mcand   <= A;
            mplier  <= B;
            acc     <= 16'd0;
            cnt     <= '0;
            lost    <= 1'b0;
            ovf_acc <= 1'b0;
            BUSY    <= 1'b1;
            state   <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          // START is deliberately not looked at here.
          acc     <= acc_next;
          ovf_acc <= ovf_next;
          lost    <= lost | mcand[15];
          mcand   <= {mcand[14:0], 1'b0};
          mplier  <= {1'b0, mplier[15:1]};
          cnt     <= cnt + 1'b1;
          if (last_iter) begin
            state <= ST_DONE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            OUT   <= acc_next;
            OVF   <= ovf_next;
          end
        end
        default: begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule
